// File: rtl/half_load_sequencer.sv
// rtl/half_load_sequencer.sv - two-requester 16-bit write sequencer over an 8-bit half-value bus (option: HLS_ROUND_ROBIN_EN)
module half_load_sequencer #(
    parameter int NUM_REGS = 4,
    parameter int IDX_W    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req0_valid,
    input  logic [IDX_W-1:0]    req0_idx,
    input  logic [15:0]         req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [IDX_W-1:0]    req1_idx,
    input  logic [15:0]         req1_data,
    output logic                req1_ready,
    output logic [7:0]          halfvalue_out,
    output logic [NUM_REGS-1:0] loadhigh,
    output logic [NUM_REGS-1:0] loadlow,
    output logic                busy,
    output logic                done,
    output logic                done_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx_q;
    logic [7:0]       data_lo_q;
    logic             id_q;

    logic             pick1;
    logic             open_window;
    logic             accept;
    logic [IDX_W-1:0] acc_idx;
    logic [15:0]      acc_data;

    // One-hot strobe decode; an index at or beyond NUM_REGS selects nothing
    function automatic logic [NUM_REGS-1:0] decode(input logic [IDX_W-1:0] i);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (i == IDX_W'(r)) begin
                v[r] = 1'b1;
            end
        end
        return v;
    endfunction

`ifdef HLS_ROUND_ROBIN_EN
    // Requester that won the most recent accept; reset value lets requester 0 win the first tie
    logic last_grant;

    // Tie goes to the requester that did not win last time
    always_comb begin
        pick1 = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    end
`else
    // Fixed priority: requester 1 only wins when requester 0 is idle
    always_comb begin
        pick1 = req1_valid && !req0_valid;
    end
`endif

    // Ready is offered only outside HIGH and never while reset is held low
    always_comb begin
        open_window = reset && (state != HIGH);
        req0_ready  = open_window && req0_valid && !pick1;
        req1_ready  = open_window && req1_valid && pick1;
        accept      = req0_ready || req1_ready;
        acc_idx     = pick1 ? req1_idx  : req0_idx;
        acc_data    = pick1 ? req1_data : req0_data;
    end

    // State machine with registered bus, strobes and completion outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            idx_q         <= '0;
            data_lo_q     <= '0;
            id_q          <= 1'b0;
            halfvalue_out <= '0;
            loadhigh      <= '0;
            loadlow       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            done_id       <= 1'b0;
`ifdef HLS_ROUND_ROBIN_EN
            last_grant    <= 1'b1;
`endif
        end else begin
            halfvalue_out <= '0;
            loadhigh      <= '0;
            loadlow       <= '0;
            done          <= 1'b0;
            case (state)
                IDLE, LOW: begin
                    if (accept) begin
                        state         <= HIGH;
                        busy          <= 1'b1;
                        idx_q         <= acc_idx;
                        data_lo_q     <= acc_data[7:0];
                        id_q          <= pick1;
                        loadhigh      <= decode(acc_idx);
                        halfvalue_out <= acc_data[15:8];
`ifdef HLS_ROUND_ROBIN_EN
                        last_grant    <= pick1;
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                HIGH: begin
                    state         <= LOW;
                    busy          <= 1'b1;
                    loadlow       <= decode(idx_q);
                    halfvalue_out <= data_lo_q;
                    done          <= 1'b1;
                    done_id       <= id_q;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
